muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq_pkg.sv | 23 ++
 rtl/muldiv_seq_step.sv | 38 +++
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned MULDIV_ITERATIONS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    trial   = {hi, lo[XLEN-1]};
    diff    = trial - {1'b0, opnd};
    hi_next = '0;
    lo_next = '0;
    if (div) begin
      // hi is the partial remainder, lo shifts dividend bits out and quotient bits in
      if (trial >= {1'b0, opnd}) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = trial[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return illegal_op.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal_op
);

  muldiv_state_t   state;
  muldiv_op_t      op_in;
  muldiv_op_t      op_q;
  logic [4:0]      cnt;
  logic            neg_q;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [XLEN-1:0] step_hi, step_lo;
  logic            step_div;

  logic            a_signed, b_signed, a_neg, b_neg, res_neg, is_div_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] final_res;

  assign start_ready = (state == ST_IDLE) && !reset;
  assign op_in       = muldiv_op_t'(op);
  assign is_div_in   = op[2];

  always_comb begin
    a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed && rs1[XLEN-1];
    b_neg    = b_signed && rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    res_neg  = ((op_in == OP_REM) || (op_in == OP_REMU)) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MULDIV_DIV_EN
  logic            special;
  logic [XLEN-1:0] special_res;

  assign step_div = op_q[2];

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div_in && (rs2 == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? rs1 : '1;
    end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end
`else
  assign step_div = 1'b0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div     (step_div),
    .hi      (hi),
    .lo      (lo),
    .opnd    (opnd),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign fix-up is applied to the last step's output so the result lands on the final CALC edge
  always_comb begin
    prod      = {step_hi, step_lo};
    prod_fix  = neg_q ? -prod : prod;
    final_res = '0;
    case (op_q)
      OP_MUL:                      final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = neg_q ? -step_lo : step_lo;
      default:                     final_res = neg_q ? -step_hi : step_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      cnt          <= '0;
      op_q         <= OP_MUL;
      neg_q        <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      opnd         <= '0;
    end else if (flush) begin
      state        <= ST_IDLE;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            op_q       <= op_in;
            neg_q      <= res_neg;
            cnt        <= 5'(MULDIV_ITERATIONS - 1);
            illegal_op <= 1'b0;
            hi         <= '0;
            lo         <= is_div_in ? a_mag : b_mag;
            opnd       <= is_div_in ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
            if (special) begin
              result <= special_res;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
`else
            if (is_div_in) begin
              result     <= '0;
              illegal_op <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state      <= ST_CALC;
            end
`endif
          end
        end
        ST_CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - 5'd1;
          if (cnt == '0) begin
            result <= final_res;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // result_valid trails DONE entry by one cycle, so it never sees a half-written result
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; divide checks follow MULDIV_DIV_EN.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start_valid = 1'b1;
    op  = o;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || result !== 32'h0 || illegal_op !== 1'b0 || start_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b result=%h illegal=%b ready=%b, want 0/00000000/0/0",
               result_valid, result, illegal_op, start_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", start_ready);
    end
  endtask

  task automatic test_mul();
    int n;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_valid(n);
    checks++;
    if (n != 33) begin
      failures++;
      $display("FAIL mul_latency: got %0d want 33", n);
    end
    checks++;
    if (result !== 32'hFFFF_FFEB || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL mul_result: got %h illegal=%b want ffffffeb illegal=0", result, illegal_op);
    end
    consume();
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'd3, 3'd1, 3'd2};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(n);
      checks++;
      if (n != 33 || result !== exp[i]) begin
        failures++;
        $display("FAIL mulh_op%0d: got %h after %0d cycles want %h after 33", ops[i], result, n, exp[i]);
      end
      consume();
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [2:0]  ops [7] = '{3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'h0};
    int          lat [7] = '{33, 33, 33, 1, 1, 1, 1};
    int n;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(n);
      checks++;
      if (n != lat[i] || result !== exp[i] || illegal_op !== 1'b0) begin
        failures++;
        $display("FAIL div_vec%0d: got %h after %0d illegal=%b want %h after %0d illegal=0",
                 i, result, n, illegal_op, exp[i], lat[i]);
      end
      consume();
    end
  endtask
`else
  task automatic test_illegal();
    int n;
    issue(3'd4, 32'd7, 32'd2);
    wait_valid(n);
    checks++;
    if (n != 1 || result !== 32'h0 || illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL div_compiled_out: got %h after %0d illegal=%b want 00000000 after 1 illegal=1",
               result, n, illegal_op);
    end
    consume();
    issue(3'd0, 32'd2, 32'd3);
    wait_valid(n);
    checks++;
    if (result !== 32'd6 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL mul_after_illegal: got %h illegal=%b want 00000006 illegal=0", result, illegal_op);
    end
    consume();
  endtask
`endif

  task automatic test_flush();
    int n;
    logic seen;
    issue(3'd0, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_calc: valid=%b ready=%b want 0/1", result_valid, start_ready);
    end
    // flush beats a simultaneous start in IDLE
    start_valid = 1'b1; op = 3'd0; rs1 = 32'd1; rs2 = 32'd1; flush = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid || !start_ready) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_result: activity=%b want 0", seen);
    end
    issue(3'd0, 32'd3, 32'd4);
    wait_valid(n);
    checks++;
    if (n != 33 || result !== 32'd12) begin
      failures++;
      $display("FAIL mul_after_flush: got %h after %0d want 0000000c after 33", result, n);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    logic bad;
    issue(3'd0, 32'h1234_5678, 32'h10);
    wait_valid(n);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (result !== 32'h2345_6780 || result_valid !== 1'b1 || start_ready !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_hold: unstable result/valid/ready (last result=%h) want 23456780 held", result);
    end
    consume();
    checks++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1 || result !== 32'h2345_6780) begin
      failures++;
      $display("FAIL backpressure_release: valid=%b ready=%b result=%h want 0/1/23456780",
               result_valid, start_ready, result);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(3'd0, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || result !== 32'h0 || illegal_op !== 1'b0 || start_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_calc: valid=%b result=%h illegal=%b ready=%b want 0/00000000/0/0",
               result_valid, result, illegal_op, start_ready);
    end
    reset = 1'b0;
    #1;
    wait_valid(n);
    checks++;
    if (n != -1 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_result: valid after %0d ready=%b want none/1", n, start_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
